// File: rtl/c16_prg_inject.sv
// PRG download injector for the C16: stalls the 8501, writes the file into RAM, releases the CPU.
// Optional BASIC pointer patch (VARTAB/ARYTAB/STREND) compiled in with C16_PRG_PTR_FIX_EN.
module c16_prg_inject #(
    parameter int WR_CYCLES    = 4,
    parameter int SYNC_TIMEOUT = 64
) (
    input  logic        CLK28,
    input  logic        RESET,
    input  logic        dl_start,
    input  logic [7:0]  dl_data,
    input  logic        dl_valid,
    input  logic        dl_last,
    output logic        dl_ready,
    input  logic        cpuenable,
    output logic        WAIT,
    output logic        busy,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_dout,
    output logic        ram_we,
    output logic        done,
    output logic        err,
    output logic [15:0] end_addr
);

    // state   | meaning
    // IDLE    | waiting for dl_start, CPU running
    // SYNC    | WAIT raised, waiting for a cpuenable pulse or timeout
    // HDR_LO  | accepting load address low byte
    // HDR_HI  | accepting load address high byte
    // DATA    | accepting a data byte
    // WRITE   | holding ram_we for WR_CYCLES cycles
    // PTR     | BASIC pointer patch (single pass-through cycle when compiled out)
    // RELEASE | drop WAIT/busy, pulse done
    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_HDR_LO,
        S_HDR_HI,
        S_DATA,
        S_WRITE,
        S_PTR,
        S_RELEASE
    } state_t;

    localparam int SYNC_W = (SYNC_TIMEOUT > 1) ? $clog2(SYNC_TIMEOUT) : 1;
    localparam logic [SYNC_W-1:0] SYNC_LOAD = SYNC_W'(SYNC_TIMEOUT - 1);
    localparam logic [3:0]        WR_LOAD   = 4'(WR_CYCLES - 1);

    state_t             state_q, state_d;
    logic [SYNC_W-1:0]  sync_cnt_q, sync_cnt_d;
    logic [3:0]         wr_cnt_q, wr_cnt_d;
    logic [7:0]         load_lo_q, load_lo_d;
    logic               last_q, last_d;
    logic               wait_q, wait_d;
    logic               busy_q, busy_d;
    logic               dl_ready_q, dl_ready_d;
    logic [15:0]        ram_addr_q, ram_addr_d;
    logic [7:0]         ram_dout_q, ram_dout_d;
    logic               ram_we_q, ram_we_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [15:0]        end_addr_q, end_addr_d;
    logic               accept;
    logic               enter_release;
`ifdef C16_PRG_PTR_FIX_EN
    logic [2:0]         ptr_idx_q, ptr_idx_d;
`endif

    assign accept = dl_valid & dl_ready_q;

    always_comb begin
        state_d       = state_q;
        sync_cnt_d    = sync_cnt_q;
        wr_cnt_d      = wr_cnt_q;
        load_lo_d     = load_lo_q;
        last_d        = last_q;
        wait_d        = wait_q;
        busy_d        = busy_q;
        dl_ready_d    = dl_ready_q;
        ram_addr_d    = ram_addr_q;
        ram_dout_d    = ram_dout_q;
        ram_we_d      = ram_we_q;
        done_d        = 1'b0;
        err_d         = err_q;
        end_addr_d    = end_addr_q;
        enter_release = 1'b0;
`ifdef C16_PRG_PTR_FIX_EN
        ptr_idx_d     = ptr_idx_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (dl_start) begin
                    err_d      = 1'b0;
                    end_addr_d = 16'h0000;
                    wait_d     = 1'b1;
                    busy_d     = 1'b1;
                    sync_cnt_d = SYNC_LOAD;
`ifdef C16_PRG_PTR_FIX_EN
                    ptr_idx_d  = 3'd0;
`endif
                    state_d    = S_SYNC;
                end
            end

            S_SYNC: begin
                // the first SYNC cycle is the one WAIT rose in, so its cpuenable is ignored
                if ((cpuenable && (sync_cnt_q != SYNC_LOAD)) || (sync_cnt_q == '0)) begin
                    dl_ready_d = 1'b1;
                    state_d    = S_HDR_LO;
                end else begin
                    sync_cnt_d = sync_cnt_q - 1'b1;
                end
            end

            S_HDR_LO: begin
                if (accept) begin
                    load_lo_d = dl_data;
                    if (dl_last) begin
                        err_d         = 1'b1;
                        enter_release = 1'b1;
                    end else begin
                        state_d = S_HDR_HI;
                    end
                end
            end

            S_HDR_HI: begin
                if (accept) begin
                    ram_addr_d = {dl_data, load_lo_q};
                    end_addr_d = {dl_data, load_lo_q};
                    if (dl_last) begin
                        dl_ready_d = 1'b0;
                        state_d    = S_PTR;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end

            S_DATA: begin
                if (accept) begin
                    ram_dout_d = dl_data;
                    last_d     = dl_last;
                    ram_we_d   = 1'b1;
                    wr_cnt_d   = WR_LOAD;
                    dl_ready_d = 1'b0;
                    state_d    = S_WRITE;
                end
            end

            S_WRITE: begin
                if (wr_cnt_q == 4'd0) begin
                    ram_we_d   = 1'b0;
                    ram_addr_d = ram_addr_q + 16'd1;
                    end_addr_d = ram_addr_q + 16'd1;
                    if (ram_addr_q == 16'hFFFF) begin
                        err_d = 1'b1;
                    end
                    if (last_q) begin
                        state_d = S_PTR;
                    end else begin
                        dl_ready_d = 1'b1;
                        state_d    = S_DATA;
                    end
                end else begin
                    wr_cnt_d = wr_cnt_q - 4'd1;
                end
            end

            S_PTR: begin
`ifdef C16_PRG_PTR_FIX_EN
                // one idle setup cycle between pointer writes keeps addr/data stable under ram_we
                if (!ram_we_q) begin
                    ram_addr_d = 16'h002D + {13'd0, ptr_idx_q};
                    ram_dout_d = ptr_idx_q[0] ? end_addr_q[15:8] : end_addr_q[7:0];
                    ram_we_d   = 1'b1;
                    wr_cnt_d   = WR_LOAD;
                end else if (wr_cnt_q == 4'd0) begin
                    ram_we_d = 1'b0;
                    if (ptr_idx_q == 3'd5) begin
                        enter_release = 1'b1;
                    end else begin
                        ptr_idx_d = ptr_idx_q + 3'd1;
                    end
                end else begin
                    wr_cnt_d = wr_cnt_q - 4'd1;
                end
`else
                enter_release = 1'b1;
`endif
            end

            S_RELEASE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (enter_release) begin
            wait_d     = 1'b0;
            busy_d     = 1'b0;
            dl_ready_d = 1'b0;
            ram_we_d   = 1'b0;
            done_d     = 1'b1;
            state_d    = S_RELEASE;
        end
    end

    always_ff @(posedge CLK28) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            sync_cnt_q <= '0;
            wr_cnt_q   <= 4'd0;
            load_lo_q  <= 8'h00;
            last_q     <= 1'b0;
            wait_q     <= 1'b0;
            busy_q     <= 1'b0;
            dl_ready_q <= 1'b0;
            ram_addr_q <= 16'h0000;
            ram_dout_q <= 8'h00;
            ram_we_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            end_addr_q <= 16'h0000;
`ifdef C16_PRG_PTR_FIX_EN
            ptr_idx_q  <= 3'd0;
`endif
        end else begin
            state_q    <= state_d;
            sync_cnt_q <= sync_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            load_lo_q  <= load_lo_d;
            last_q     <= last_d;
            wait_q     <= wait_d;
            busy_q     <= busy_d;
            dl_ready_q <= dl_ready_d;
            ram_addr_q <= ram_addr_d;
            ram_dout_q <= ram_dout_d;
            ram_we_q   <= ram_we_d;
            done_q     <= done_d;
            err_q      <= err_d;
            end_addr_q <= end_addr_d;
`ifdef C16_PRG_PTR_FIX_EN
            ptr_idx_q  <= ptr_idx_d;
`endif
        end
    end

    assign dl_ready = dl_ready_q;
    assign WAIT     = wait_q;
    assign busy     = busy_q;
    assign ram_addr = ram_addr_q;
    assign ram_dout = ram_dout_q;
    assign ram_we   = ram_we_q;
    assign done     = done_q;
    assign err      = err_q;
    assign end_addr = end_addr_q;

endmodule

// File: doc/c16_prg_inject.md
Name: c16_prg_inject

Overview:
- Controller that injects a PRG file from the host download stream into C16 RAM.
- Stalls the 8501 through the core's WAIT input and owns the RAM write port while active.
- Optionally patches the BASIC end pointers afterwards, then releases the CPU.
- Sits beside the C16 core; its RAM port is muxed ahead of the core's RAM port while busy=1.

Parameters:
- WR_CYCLES, 4, CLK28 cycles ram_we is held per byte (1..15).
- SYNC_TIMEOUT, 64, CLK28 cycles to wait for a cpuenable pulse before forcing ownership.

Ports:
- CLK28  in  1  system clock (28 MHz).
- RESET  in  1  synchronous, active-high reset.
- dl_start  in  1  one-cycle pulse: begin a new PRG transfer.
- dl_data  in  8  download byte.
- dl_valid  in  1  dl_data valid.
- dl_last  in  1  qualifies the current byte as the final byte of the file.
- dl_ready  out  1  byte accepted in this cycle when dl_valid & dl_ready.
- cpuenable  in  1  CPU clock-enable pulse from TED (sampled, never gated).
- WAIT  out  1  stall request to the C16 core.
- busy  out  1  block owns RAM; external mux selects ram_* outputs.
- ram_addr  out  16  RAM write address.
- ram_dout  out  8  RAM write data.
- ram_we  out  1  RAM write strobe.
- done  out  1  one-cycle pulse at end of transfer.
- err  out  1  sticky: header truncated or address wrapped; cleared by dl_start.
- end_addr  out  16  first address after the last data byte written.

Behaviour:
- Reset values: WAIT=0, busy=0, dl_ready=0, ram_we=0, ram_addr=0, ram_dout=0, done=0, err=0, end_addr=0; state=IDLE.
- RESET mid-transfer aborts immediately. WAIT falls the cycle after RESET is sampled. No further writes occur.
- States: IDLE, SYNC, HDR_LO, HDR_HI, DATA, WRITE, PTR, RELEASE.
- IDLE, on dl_start: clear err, set WAIT=1 and busy=1, go to SYNC. dl_start is ignored in every other state.
- SYNC: count cycles. Exit to HDR_LO on the first cpuenable=1 seen at least one cycle after WAIT rose, or when the count reaches SYNC_TIMEOUT. dl_ready=0.
- HDR_LO / HDR_HI: dl_ready=1.
  - Accepted byte loads load_addr[7:0] or load_addr[15:8].
  - HDR_HI then goes to DATA with ram_addr=load_addr and end_addr=load_addr.
  - dl_last on the HDR_LO byte: set err, go to RELEASE (no writes).
  - dl_last on the HDR_HI byte: empty file, go to PTR.
- DATA: dl_ready=1. On accept: ram_dout=dl_data, latch last flag, go to WRITE. dl_ready is 0 in every state except HDR_LO, HDR_HI and DATA.
- WRITE:
  - ram_we=1 for exactly WR_CYCLES cycles, with ram_addr and ram_dout stable throughout.
  - On exit: ram_addr+1 (16-bit wrap), end_addr=ram_addr+1.
  - If the increment wraps FFFF->0000, set err. The transfer continues and writes at the wrapped address.
  - Next state: PTR if last flag set, else DATA. Worst-case throughput is 1 byte per WR_CYCLES+1 cycles.
- PTR: see Optional Feature. When compiled out, PTR passes straight to RELEASE in one cycle.
- RELEASE:
  - WAIT=0, busy=0, done=1 for one cycle, then IDLE.
  - end_addr and err hold until the next dl_start or RESET.
- Back-pressure: dl_valid without dl_ready is held by the source. No byte is dropped or duplicated.

Optional Feature:
- Macro: C16_PRG_PTR_FIX_EN.
- When defined, PTR performs 6 sequential writes, each WR_CYCLES long, of end_addr little-endian to:
  - $002D/$002E (VARTAB),
  - $002F/$0030 (ARYTAB),
  - $0031/$0032 (STREND).
- The writes go in ascending address order, then the state machine moves to RELEASE.
- When undefined, no pointer writes occur and PTR lasts one cycle.

Test Plan:
- Reset/idle: RESET high, then dl_valid bursts -> dl_ready=0, WAIT=0, ram_we=0; all outputs at reset values.
- Normal load: stream 01 10 AA BB CC (last on CC) -> writes AA@$1001, BB@$1002, CC@$1003, each ram_we exactly 4 cycles; end_addr=$1004; done pulse; WAIT released; err=0.
- Pointer fix (macro on): same stream -> additional writes 04,10 at $2D/$2E, $2F/$30, $31/$32 in order before done. Macro off -> no writes below $1001.
- Sync: dl_start with cpuenable held 0 -> HDR accept begins exactly after 64 cycles. With a cpuenable pulse 5 cycles after WAIT -> header accepted on the next cycle.
- Boundaries:
  - Header 01 (last) -> err=1, no ram_we, done.
  - Header FF FF then 11 22 -> 11@$FFFF, 22@$0000, err=1, end_addr=$0001.
- Abort/back-pressure: RESET during the second WRITE -> WAIT=0 next cycle, no further ram_we. dl_valid toggling randomly -> written bytes match the input order exactly.
